// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I types and encodings for the ID/EX stage
//
// Purpose: ID/EX control bundle type, result-source and ALU encodings,
//          register-index constants, and a bubble helper.
// Ports:   none (package).
package riscv_pkg;

  localparam int ALU_CTRL_W = 4;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam logic [1:0] RESULT_SRC_ALU = 2'd0;
  localparam logic [1:0] RESULT_SRC_MEM = 2'd1;
  localparam logic [1:0] RESULT_SRC_PC4 = 2'd2;
  localparam logic [1:0] RESULT_SRC_IMM = 2'd3;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'd9;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  alu_src;
    logic                  branch;
    logic                  jump;
    logic [1:0]            result_src;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
  } id_ex_ctrl_t;

  // Control word of a bubble: nothing is written anywhere downstream.
  function automatic id_ex_ctrl_t ctrl_bubble();
    return '0;
  endfunction

endpackage

// File: rtl/id_ex_hazard.sv
// rtl/id_ex_hazard.sv - load-use hazard detection and IF/ID stall generation
//
// Purpose: flags a load in EX whose destination is read by the instruction
//          in ID, and derives the front-end stall.
// Ports:
//   ex_valid, ex_mem_read, ex_rd   in   state of the instruction in EX
//   id_valid, id_rs1, id_rs2       in   sources of the instruction in ID
//   ex_flush, ext_stall            in   flush from EX, downstream freeze
//   load_use                       out  load-use hazard present
//   stall_if_id                    out  hold PC and IF/ID this cycle
module id_ex_hazard
  import riscv_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_flush,
  input  logic       ext_stall,
  output logic       load_use,
  output logic       stall_if_id
);

  // A load into x0 produces nothing worth waiting for.
  assign load_use = ex_valid & ex_mem_read & (ex_rd != REG_X0) & id_valid &
                    ((id_rs1 == ex_rd) | (id_rs2 == ex_rd));

  // A flush kills the dependent instruction anyway, so it must not stall.
  assign stall_if_id = ext_stall | (load_use & ~ex_flush);

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with load-use bubble insertion
//
// Purpose: captures decoded operands/control from ID and drives EX. Holds on
//          ext_stall, inserts a bubble on EX_flush or load-use.
// Build option: macro ID_EX_PERF_EN enables the saturating bubble/flush
//          counters; otherwise bubble_cnt/flush_cnt are tied to zero.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   ID_valid, ID_pc, ID_rs1_data,
//   ID_rs2_data, ID_imm, ID_rs1,
//   ID_rs2, ID_rd, ID_ctrl            in   instruction in ID
//   EX_flush, ext_stall               in   flush / freeze requests
//   EX_valid, EX_pc, EX_rs1_data,
//   EX_rs2_data, EX_imm, EX_rs1,
//   EX_rs2, EX_rd, EX_ctrl            out  registered instruction in EX
//   Stall_IF_ID                       out  combinational front-end stall
//   bubble_cnt, flush_cnt             out  perf counters
module id_ex_reg
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_valid,
  input  logic [XLEN-1:0]  ID_pc,
  input  logic [XLEN-1:0]  ID_rs1_data,
  input  logic [XLEN-1:0]  ID_rs2_data,
  input  logic [XLEN-1:0]  ID_imm,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [4:0]       ID_rd,
  input  id_ex_ctrl_t      ID_ctrl,
  input  logic             EX_flush,
  input  logic             ext_stall,
  output logic             EX_valid,
  output logic [XLEN-1:0]  EX_pc,
  output logic [XLEN-1:0]  EX_rs1_data,
  output logic [XLEN-1:0]  EX_rs2_data,
  output logic [XLEN-1:0]  EX_imm,
  output logic [4:0]       EX_rs1,
  output logic [4:0]       EX_rs2,
  output logic [4:0]       EX_rd,
  output id_ex_ctrl_t      EX_ctrl,
  output logic             Stall_IF_ID,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic load_use;

  logic            valid_q,    valid_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic [4:0]      rs1_q,      rs1_d;
  logic [4:0]      rs2_q,      rs2_d;
  logic [4:0]      rd_q,       rd_d;
  id_ex_ctrl_t     ctrl_q,     ctrl_d;

  id_ex_hazard u_hazard (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd       (rd_q),
    .id_valid    (ID_valid),
    .id_rs1      (ID_rs1),
    .id_rs2      (ID_rs2),
    .ex_flush    (EX_flush),
    .ext_stall   (ext_stall),
    .load_use    (load_use),
    .stall_if_id (Stall_IF_ID)
  );

  // Priority: freeze > flush > load-use bubble > capture. Bubbles only clear
  // valid/ctrl; data fields hold since nothing downstream consumes them.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    ctrl_d     = ctrl_q;
    if (ext_stall) begin
      // frozen; a pending flush is re-asserted by the branch unit later
    end else if (EX_flush || load_use) begin
      valid_d = 1'b0;
      ctrl_d  = ctrl_bubble();
    end else begin
      valid_d    = ID_valid;
      pc_d       = ID_pc;
      rs1_data_d = ID_rs1_data;
      rs2_data_d = ID_rs2_data;
      imm_d      = ID_imm;
      rs1_d      = ID_rs1;
      rs2_d      = ID_rs2;
      rd_d       = ID_rd;
      ctrl_d     = ID_valid ? ID_ctrl : ctrl_bubble();
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign EX_valid    = valid_q;
  assign EX_pc       = pc_q;
  assign EX_rs1_data = rs1_data_q;
  assign EX_rs2_data = rs2_data_q;
  assign EX_imm      = imm_q;
  assign EX_rs1      = rs1_q;
  assign EX_rs2      = rs2_q;
  assign EX_rd       = rd_q;
  assign EX_ctrl     = ctrl_q;

`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

  // Count only edges where the bubble is actually applied; saturate.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (!ext_stall && EX_flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
    if (!ext_stall && !EX_flush && load_use && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - directed scoreboard bench for id_ex_reg
module tb_id_ex_reg;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ID_valid;
  logic [31:0] ID_pc, ID_rs1_data, ID_rs2_data, ID_imm;
  logic [4:0]  ID_rs1, ID_rs2, ID_rd;
  id_ex_ctrl_t ID_ctrl;
  logic        EX_flush, ext_stall;
  logic        EX_valid;
  logic [31:0] EX_pc, EX_rs1_data, EX_rs2_data, EX_imm;
  logic [4:0]  EX_rs1, EX_rs2, EX_rd;
  id_ex_ctrl_t EX_ctrl;
  logic        Stall_IF_ID;
  logic [15:0] bubble_cnt, flush_cnt;

  id_ex_reg dut (
    .clk(clk), .rst_n(rst_n),
    .ID_valid(ID_valid), .ID_pc(ID_pc), .ID_rs1_data(ID_rs1_data),
    .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm), .ID_rs1(ID_rs1),
    .ID_rs2(ID_rs2), .ID_rd(ID_rd), .ID_ctrl(ID_ctrl),
    .EX_flush(EX_flush), .ext_stall(ext_stall),
    .EX_valid(EX_valid), .EX_pc(EX_pc), .EX_rs1_data(EX_rs1_data),
    .EX_rs2_data(EX_rs2_data), .EX_imm(EX_imm), .EX_rs1(EX_rs1),
    .EX_rs2(EX_rs2), .EX_rd(EX_rd), .EX_ctrl(EX_ctrl),
    .Stall_IF_ID(Stall_IF_ID), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    id_ex_ctrl_t ctrl;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int checks = 0;
  int errors = 0;
  int n_bubble = 0;
  int n_flush = 0;
  id_ex_ctrl_t ct_add, ct_lw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef ID_EX_PERF_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic present(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input id_ex_ctrl_t c);
    ID_valid    = v;
    ID_pc       = pc;
    ID_rs1_data = 32'h1000_0000 | pc;
    ID_rs2_data = 32'h2000_0000 | pc;
    ID_imm      = 32'hFFFF_F000 | pc;
    ID_rs1      = rs1;
    ID_rs2      = rs2;
    ID_rd       = rd;
    ID_ctrl     = c;
  endtask

  task automatic exp_capture();
    exp_t e;
    e.v = ID_valid; e.pc = ID_pc; e.rs1d = ID_rs1_data; e.rs2d = ID_rs2_data;
    e.imm = ID_imm; e.rs1 = ID_rs1; e.rs2 = ID_rs2; e.rd = ID_rd;
    e.ctrl = ID_valid ? ID_ctrl : '0;
    sb.push_back(e);
    cur = e;
  endtask

  task automatic exp_bubble();
    exp_t e;
    e = cur; e.v = 1'b0; e.ctrl = '0;
    sb.push_back(e);
    cur = e;
  endtask

  task automatic exp_hold();
    sb.push_back(cur);
  endtask

  task automatic stall_is(input string tag, input logic exp);
    #1;
    check(tag, 32'(Stall_IF_ID), 32'(exp));
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, 32'(EX_valid), 32'(e.v));
      check({tag, "_ctrl"},  32'(EX_ctrl),  32'(e.ctrl));
      check({tag, "_pc"},    EX_pc,         e.pc);
      check({tag, "_rs1d"},  EX_rs1_data,   e.rs1d);
      check({tag, "_rs2d"},  EX_rs2_data,   e.rs2d);
      check({tag, "_imm"},   EX_imm,        e.imm);
      check({tag, "_rs1"},   32'(EX_rs1),   32'(e.rs1));
      check({tag, "_rs2"},   32'(EX_rs2),   32'(e.rs2));
      check({tag, "_rd"},    32'(EX_rd),    32'(e.rd));
    end
    check({tag, "_bubble_cnt"}, 32'(bubble_cnt), cnt_exp(n_bubble));
    check({tag, "_flush_cnt"},  32'(flush_cnt),  cnt_exp(n_flush));
  endtask

  initial begin
    ct_add = '0; ct_add.reg_write = 1'b1; ct_add.alu_ctrl = ALU_ADD;
    ct_lw  = '0; ct_lw.reg_write = 1'b1; ct_lw.mem_read = 1'b1; ct_lw.alu_src = 1'b1;
    ct_lw.result_src = RESULT_SRC_MEM; ct_lw.alu_ctrl = ALU_ADD;

    // Reset held while ID offers a writing instruction
    rst_n = 1'b0; EX_flush = 1'b0; ext_stall = 1'b0;
    present(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, ct_add);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(EX_valid), 32'd0);
    check("rst_ctrl",  32'(EX_ctrl),  32'd0);
    check("rst_pc",    EX_pc,         32'd0);
    check("rst_rd",    32'(EX_rd),    32'd0);
    check("rst_stall", 32'(Stall_IF_ID), 32'd0);
    check("rst_bcnt",  32'(bubble_cnt), 32'd0);
    check("rst_fcnt",  32'(flush_cnt),  32'd0);
    rst_n = 1'b1;
    cur = '{v: 1'b0, pc: 32'd0, rs1d: 32'd0, rs2d: 32'd0, imm: 32'd0,
            rs1: 5'd0, rs2: 5'd0, rd: 5'd0, ctrl: '0};

    // Pass-through: add x3,x1,x2 @0x10
    present(1'b1, 32'h10, 5'd1, 5'd2, 5'd3, ct_add);
    stall_is("pass_stall", 1'b0);
    exp_capture(); tick("pass");

    // Load-use: lw x5 then add x6,x5,x1
    present(1'b1, 32'h14, 5'd2, 5'd0, 5'd5, ct_lw);
    stall_is("lw5_stall", 1'b0);
    exp_capture(); tick("lw5");
    present(1'b1, 32'h18, 5'd5, 5'd1, 5'd6, ct_add);
    stall_is("lu_stall", 1'b1);
    n_bubble++; exp_bubble(); tick("lu_bubble");
    stall_is("lu_release", 1'b0);
    exp_capture(); tick("lu_add");

    // Load to x0: dependent read of x0 must not stall
    present(1'b1, 32'h1c, 5'd1, 5'd0, 5'd0, ct_lw);
    exp_capture(); tick("lw0");
    present(1'b1, 32'h20, 5'd0, 5'd1, 5'd7, ct_add);
    stall_is("x0_stall", 1'b0);
    exp_capture(); tick("x0_add");

    // Flush and load-use together: flush wins, no front-end stall
    present(1'b1, 32'h24, 5'd1, 5'd0, 5'd8, ct_lw);
    exp_capture(); tick("lw8");
    present(1'b1, 32'h28, 5'd8, 5'd8, 5'd9, ct_add);
    EX_flush = 1'b1;
    stall_is("fl_lu_stall", 1'b0);
    n_flush++; exp_bubble(); tick("fl_lu");
    EX_flush = 1'b0;
    stall_is("fl_after_stall", 1'b0);
    exp_capture(); tick("add9");

    // ext_stall with flush pending for 3 cycles, flush lands on first free edge
    present(1'b1, 32'h2c, 5'd9, 5'd0, 5'd10, ct_add);
    ext_stall = 1'b1; EX_flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stall_is("xs_stall", 1'b1);
      exp_hold(); tick("xs_hold");
    end
    ext_stall = 1'b0;
    stall_is("xs_free_stall", 1'b0);
    n_flush++; exp_bubble(); tick("xs_flush");
    EX_flush = 1'b0;
    exp_capture(); tick("add10");

    // Invalid ID instruction: EX_ctrl must be zero
    present(1'b0, 32'h30, 5'd1, 5'd2, 5'd11, ct_lw);
    exp_capture(); tick("invalid");
    present(1'b1, 32'h34, 5'd1, 5'd2, 5'd12, ct_add);
    exp_capture(); tick("add12");

    // Reset asserted mid-stall clears outputs without a clock edge
    ext_stall = 1'b1;
    exp_hold(); tick("pre_rst_hold");
    rst_n = 1'b0;
    n_bubble = 0; n_flush = 0;
    #1;
    check("mrst_valid", 32'(EX_valid), 32'd0);
    check("mrst_ctrl",  32'(EX_ctrl),  32'd0);
    check("mrst_pc",    EX_pc,         32'd0);
    check("mrst_rd",    32'(EX_rd),    32'd0);
    check("mrst_stall", 32'(Stall_IF_ID), 32'd1);
    check("mrst_bcnt",  32'(bubble_cnt), 32'd0);
    check("mrst_fcnt",  32'(flush_cnt),  32'd0);
    ext_stall = 1'b0;
    stall_is("mrst_stall_drop", 1'b0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
